// File: rtl/dmem_access_unit.sv
// -----------------------------------------------------------------------------
// dmem_access_unit
//
// Load/store initiator for the word-wide DataMemory port. It takes one
// byte-addressed request at a time and turns it into word accesses:
//   - word store           : a single write
//   - load (any size)      : a read, waits READ_LATENCY, then extracts and
//                            extends the addressed lane
//   - byte/halfword store  : read-modify-write, because the memory only
//                            writes whole 32-bit words
// Misaligned or illegal-size requests complete with resp_err and never
// touch memory.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid / req_ready     request handshake (ready only in IDLE)
//   req_write, req_size,      store flag, size (00 B, 01 H, 10 W, 11 illegal),
//   req_signed                sign-extend flag for loads
//   req_addr, req_wdata       byte address, right-aligned store data
//   resp_valid, resp_rdata,   one-cycle completion pulse, load data
//   resp_err                  (0 for stores/errors) and error flag
//   memWrite, memRead,        DataMemory strobes, word address and
//   data_addr, writeData,     write data
//   readData                  DataMemory read data
//
// Every output is decoded from registered state and gated by rst, so all
// outputs read 0 while reset is held.
// -----------------------------------------------------------------------------
module dmem_access_unit #(
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              memWrite,
    output logic              memRead,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       writeData,
    input  logic [31:0]       readData
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ERR     = 3'd1,
        RD      = 3'd2,
        RD_WAIT = 3'd3,
        WR      = 3'd4,
        RESP    = 3'd5
    } state_t;

    // RD_WAIT lasts READ_LATENCY cycles; the last one is the capture cycle.
    localparam logic [2:0] LAST_CNT = 3'(READ_LATENCY - 1);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q;
    logic [ADDR_W+1:0] addr_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic              write_q;
    // Holds store data from accept, then the merged word (sub-word store)
    // or the extended load result after the read completes.
    logic [31:0]       data_q;

    logic              misaligned;
    logic              capture;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    assign misaligned = (req_size == 2'b11) ||
                        (req_size == 2'b01 && req_addr[0]) ||
                        (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    assign capture = (state_q == RD_WAIT) && (cnt_q == LAST_CNT);

    // Lane extraction and extension for loads.
    always_comb begin
        byte_lane = readData[{addr_q[1:0], 3'b000} +: 8];
        half_lane = readData[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_val = {{24{signed_q & byte_lane[7]}}, byte_lane};
            2'b01:   load_val = {{16{signed_q & half_lane[15]}}, half_lane};
            default: load_val = readData;
        endcase
    end

    // Sub-word store merge: only the addressed lane is replaced.
    always_comb begin
        merged = readData;
        case (size_q)
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
            default: merged = data_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned)
                        state_d = ERR;
                    else if (req_write && req_size == 2'b10)
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            ERR:     state_d = IDLE;
            RD:      state_d = RD_WAIT;
            RD_WAIT: if (cnt_q == LAST_CNT) state_d = write_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                addr_q   <= req_addr;
                size_q   <= req_size;
                signed_q <= req_signed;
                write_q  <= req_write;
                data_q   <= req_wdata;
                cnt_q    <= '0;
            end
            if (state_q == RD_WAIT)
                cnt_q <= cnt_q + 3'd1;
            if (capture)
                data_q <= write_q ? merged : load_val;
        end
    end

    assign req_ready  = !rst && (state_q == IDLE);
    assign resp_valid = !rst && (state_q == RESP || state_q == ERR);
    assign resp_err   = !rst && (state_q == ERR);
    assign resp_rdata = (!rst && state_q == RESP && !write_q) ? data_q : 32'h0;
    assign memRead    = !rst && (state_q == RD);
    assign memWrite   = !rst && (state_q == WR);
    assign writeData  = (!rst && state_q == WR) ? data_q : 32'h0;
    assign data_addr  = rst ? '0 : addr_q[ADDR_W+1:2];

endmodule

// File: tb/tb_dmem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_unit
//
// Three units (READ_LATENCY 2, 1, 4) each with a private DataMemory model.
// Expected writes and responses are pushed to scoreboard queues when a
// request is issued, and popped when the unit strobes memWrite/resp_valid.
// A shadow copy of each memory supplies expected data.
// -----------------------------------------------------------------------------
module tb_dmem_access_unit;

    logic clk;
    logic rst;
    logic [2:0]        req_valid;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [11:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [2:0]        req_ready, resp_valid, resp_err, memWrite, memRead;
    logic [2:0][31:0]  resp_rdata, writeData, readData;
    logic [2:0][9:0]   data_addr;

    typedef struct { logic [9:0] addr; logic [31:0] data; int cyc; } wr_t;
    typedef struct { logic [31:0] data; logic err; int cyc; } resp_t;

    wr_t   wr_q[$];
    resp_t resp_q[$];
    logic [31:0] shadow [3][1024];
    int ncmp = 0;
    int nfail = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 3; g++) begin : g_u
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        logic [31:0] mem [1024];
        logic [31:0] rd_pipe [LAT];

        dmem_access_unit #(.ADDR_W(10), .READ_LATENCY(LAT)) u_dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
            .req_addr(req_addr), .req_wdata(req_wdata),
            .resp_valid(resp_valid[g]), .resp_rdata(resp_rdata[g]),
            .resp_err(resp_err[g]),
            .memWrite(memWrite[g]), .memRead(memRead[g]),
            .data_addr(data_addr[g]), .writeData(writeData[g]),
            .readData(readData[g])
        );

        // Synchronous memory: data read in cycle c appears in cycle c+LAT.
        always @(posedge clk) begin
            if (memWrite[g]) mem[data_addr[g]] <= writeData[g];
            if (memRead[g])  rd_pipe[0] <= mem[data_addr[g]];
            for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
        assign readData[g] = rd_pipe[LAT-1];
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rst_outs(input int d);
        chk("rst_flags", {27'h0, req_ready[d], resp_valid[d], resp_err[d],
                          memWrite[d], memRead[d]}, 32'h0);
        chk("rst_rdata", resp_rdata[d], 32'h0);
        chk("rst_wdata", writeData[d], 32'h0);
        chk("rst_addr",  {22'h0, data_addr[d]}, 32'h0);
    endtask

    // Drive the request and wait for acceptance (bounded). Leaves the bench
    // sampling cycle 1 after the accept edge.
    task automatic issue(input int d, input bit wr, input logic [1:0] sz,
                         input bit sg, input logic [11:0] a, input logic [31:0] wd);
        int w = 0;
        req_write = wr; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        req_valid[d] = 1'b1;
        while (!req_ready[d] && w < 20) begin tick(); w++; end
        chk("accept_wait", {31'h0, req_ready[d]}, 32'h1);
        tick();
        req_valid[d] = 1'b0;
    endtask

    task automatic txn(input int d, input bit wr, input logic [1:0] sz,
                       input bit sg, input logic [11:0] a, input logic [31:0] wd);
        int L = lat_of(d);
        bit err;
        logic [31:0] w, res, m;
        int exp_rd = 0, exp_wr = 0, reads = 0, writes = 0, rd_cyc = -1;
        bit done = 0;
        wr_t we;
        resp_t re;

        err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        w = shadow[d][a[11:2]];
        if (err) begin
            resp_q.push_back('{data: 32'h0, err: 1'b1, cyc: 1});
        end else if (!wr) begin
            exp_rd = 1;
            if (sz == 2'b00) begin
                res = (w >> (8 * a[1:0])) & 32'hFF;
                if (sg && res[7]) res = res | 32'hFFFF_FF00;
            end else if (sz == 2'b01) begin
                res = (w >> (16 * a[1])) & 32'hFFFF;
                if (sg && res[15]) res = res | 32'hFFFF_0000;
            end else begin
                res = w;
            end
            resp_q.push_back('{data: res, err: 1'b0, cyc: 2 + L});
        end else if (sz == 2'b10) begin
            exp_wr = 1;
            wr_q.push_back('{addr: a[11:2], data: wd, cyc: 1});
            shadow[d][a[11:2]] = wd;
            resp_q.push_back('{data: 32'h0, err: 1'b0, cyc: 2});
        end else begin
            exp_rd = 1; exp_wr = 1;
            if (sz == 2'b00)
                m = (w & ~(32'hFF << (8 * a[1:0]))) | ((wd & 32'hFF) << (8 * a[1:0]));
            else
                m = (w & ~(32'hFFFF << (16 * a[1]))) | ((wd & 32'hFFFF) << (16 * a[1]));
            wr_q.push_back('{addr: a[11:2], data: m, cyc: 2 + L});
            shadow[d][a[11:2]] = m;
            resp_q.push_back('{data: 32'h0, err: 1'b0, cyc: 3 + L});
        end

        issue(d, wr, sz, sg, a, wd);
        for (int n = 1; n <= 16 && !done; n++) begin
            chk("strobe_excl", {31'h0, memRead[d] & memWrite[d]}, 32'h0);
            if (memRead[d]) begin
                reads++;
                if (rd_cyc < 0) rd_cyc = n;
                chk("rd_addr", {22'h0, data_addr[d]}, {22'h0, a[11:2]});
            end
            if (memWrite[d]) begin
                writes++;
                chk("wr_expected", {31'h0, wr_q.size() > 0}, 32'h1);
                if (wr_q.size() > 0) begin
                    we = wr_q.pop_front();
                    chk("wr_addr", {22'h0, data_addr[d]}, {22'h0, we.addr});
                    chk("wr_data", writeData[d], we.data);
                    chk("wr_cycle", n, we.cyc);
                end
            end
            if (resp_valid[d]) begin
                done = 1;
                chk("resp_expected", {31'h0, resp_q.size() > 0}, 32'h1);
                if (resp_q.size() > 0) begin
                    re = resp_q.pop_front();
                    chk("resp_rdata", resp_rdata[d], re.data);
                    chk("resp_err", {31'h0, resp_err[d]}, {31'h0, re.err});
                    chk("resp_cycle", n, re.cyc);
                end
            end
            tick();
        end
        chk("resp_timeout", {31'h0, done}, 32'h1);
        chk("ready_after", {31'h0, req_ready[d]}, 32'h1);
        chk("read_count", reads, exp_rd);
        chk("write_count", writes, exp_wr);
        if (exp_rd != 0) chk("read_cycle", rd_cyc, 1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        #1;
        chk_rst_outs(0);
        tick();
        tick();
        chk_rst_outs(0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", {29'h0, req_ready}, 32'h7);

        // Word store then word load (L=2).
        txn(0, 1, 2'b10, 0, 12'd36, 32'd24);
        txn(0, 0, 2'b10, 0, 12'd36, 32'h0);

        // Sub-word store merge and extension.
        txn(0, 1, 2'b10, 0, 12'd12, 32'h1122_3344);
        txn(0, 1, 2'b00, 0, 12'd13, 32'hFFFF_FFAB);
        txn(0, 0, 2'b00, 1, 12'd13, 32'h0);
        txn(0, 0, 2'b01, 0, 12'd14, 32'h0);
        txn(0, 0, 2'b00, 0, 12'd13, 32'h0);
        txn(0, 0, 2'b01, 1, 12'd12, 32'h0);
        txn(0, 1, 2'b01, 0, 12'd14, 32'h1234_BEEF);
        txn(0, 0, 2'b10, 0, 12'd12, 32'h0);
        txn(0, 1, 2'b00, 0, 12'd15, 32'h0000_0077);
        txn(0, 0, 2'b00, 1, 12'd15, 32'h0);

        // Misaligned and illegal requests.
        txn(0, 0, 2'b10, 0, 12'd38, 32'h0);
        txn(0, 1, 2'b01, 0, 12'd5,  32'hDEAD_BEEF);
        txn(0, 0, 2'b11, 0, 12'd0,  32'h0);
        txn(0, 1, 2'b10, 0, 12'd2,  32'h5555_5555);

        // Latency sweep: L=1 and L=4.
        txn(1, 1, 2'b10, 0, 12'd36, 32'd24);
        txn(1, 0, 2'b10, 0, 12'd36, 32'h0);
        txn(2, 1, 2'b10, 0, 12'd36, 32'd24);
        txn(2, 0, 2'b10, 0, 12'd36, 32'h0);
        txn(2, 1, 2'b00, 0, 12'd37, 32'h0000_0080);
        txn(2, 0, 2'b00, 1, 12'd37, 32'h0);
        txn(1, 1, 2'b01, 0, 12'd38, 32'h0000_CAFE);
        txn(1, 0, 2'b01, 1, 12'd38, 32'h0);

        // Reset in cycle 2 of a byte store: aborted, memory untouched.
        issue(0, 1, 2'b00, 0, 12'd37, 32'h0000_00EE);
        chk("abort_rd_c1", {31'h0, memRead[0]}, 32'h1);
        tick();
        rst = 1'b1;
        #1;
        chk_rst_outs(0);
        tick();
        chk_rst_outs(0);
        tick();
        chk_rst_outs(0);
        rst = 1'b0;
        #1;
        chk("ready_after_abort", {31'h0, req_ready[0]}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            chk("post_abort_quiet", {30'h0, memWrite[0], resp_valid[0]}, 32'h0);
            tick();
        end
        txn(0, 0, 2'b10, 0, 12'd36, 32'h0);

        chk("queues_drained", wr_q.size() + resp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Load/store initiator that drives the word-wide `DataMemory` port (`memWrite`, `memRead`, `data_addr`, `writeData`, `readData`) on behalf of the RISC datapath. It accepts one byte-addressed request at a time over a valid/ready handshake and waits out the memory's synchronous read latency. It performs sign- or zero-extended byte and halfword loads. Sub-word stores are done as read-modify-write, because `DataMemory` writes only whole 32-bit words.

## Interface
- `ADDR_W`, 10, word-address width of `DataMemory`; the byte address is `ADDR_W+2` bits.
- `READ_LATENCY`, 2, cycles from the `memRead` cycle to valid `readData`; legal range 1..4.

- `clk` in 1: the single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: the request is present.
- `req_ready` out 1: the unit can accept a request; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- `req_signed` in 1: sign-extend loads; ignored for stores.
- `req_addr` in ADDR_W+2: byte address, little-endian.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse; there is no backpressure.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned or illegal request; qualified by `resp_valid`.
- `memWrite` out 1: write strobe to `DataMemory`.
- `memRead` out 1: read strobe to `DataMemory`.
- `data_addr` out ADDR_W: word address, equal to `req_addr[ADDR_W+1:2]`.
- `writeData` out 32: word to write; 0 whenever `memWrite` = 0.
- `readData` in 32: word returned by `DataMemory`.

## Operation
- **FSM states:** IDLE, ERR, RD, RD_WAIT, WR, RESP.
- **Accept:** a request is accepted on a clock edge where `req_valid && req_ready`. The address, size, signed flag, write flag and data are registered at that edge. `data_addr` is held constant from acceptance until the unit returns to IDLE.
- **Error check:** a request is misaligned if `req_size`=11, or a halfword has `addr[0]`=1, or a word has `addr[1:0]`≠0.
  - Transition: IDLE→ERR→IDLE.
  - ERR: `resp_valid`=1, `resp_err`=1.
  - No `memRead` or `memWrite` is ever asserted for an error request.
- **Word store:** IDLE→WR→RESP→IDLE. In WR, `memWrite`=1 and `writeData`=`req_wdata`.
- **Load, or byte/halfword store:** IDLE→RD→RD_WAIT→…
  - RD: `memRead`=1 for exactly one cycle.
  - RD_WAIT: counts READ_LATENCY−1 further cycles, then captures `readData` at the edge ending cycle RD+READ_LATENCY.
- **Load completion:** RD_WAIT→RESP.
  - The lane is `addr[1:0]` (byte) or `addr[1]` (halfword).
  - The selected lane is extended by `req_signed`. Word loads pass through unchanged.
- **Sub-word store completion:** RD_WAIT→WR→RESP.
  - The captured word has only the target lane replaced, by `req_wdata[7:0]` or `req_wdata[15:0]`.
  - All other bytes are preserved bit-exact.
- **RESP:** `resp_valid`=1 for one cycle, `resp_err`=0, then IDLE.
- **Strobe exclusivity:** `memRead` and `memWrite` are never high in the same cycle.
- **Reset:**
  - While `rst`=1, every output is 0: `req_ready`, `resp_valid`, `resp_rdata`, `resp_err`, `memWrite`, `memRead`, `data_addr` and `writeData`.
  - The state goes to IDLE. `req_ready`=1 in the first cycle after `rst` falls.
- **Reset mid-operation:** the transaction is aborted. Strobes are 0 from the cycle after the reset edge, and no response is issued.
- **Back-to-back:** a new request is accepted in the IDLE cycle after RESP or ERR. Requests presented while `req_ready`=0 are held by the requester, not dropped.

## Timing
Cycle 0 is the accept edge; cycle n is the nth cycle after it. L = READ_LATENCY.
- **Error request:** `resp_valid` in cycle 1; `req_ready` in cycle 2.
- **Word store:** `memWrite` in cycle 1; `resp_valid` in cycle 2; `req_ready` in cycle 3.
- **Load:**
  - `memRead` in cycle 1.
  - `readData` is sampled at the end of cycle 1+L.
  - `resp_valid` and `resp_rdata` in cycle 2+L; `req_ready` in cycle 3+L.
  - With L=2: response in cycle 4.
- **Sub-word store:**
  - `memRead` in cycle 1.
  - `memWrite` with the merged word in cycle 2+L.
  - `resp_valid` in cycle 3+L; `req_ready` in cycle 4+L.
- **Output timing:** all outputs are registered or decoded from state only. No combinational path runs from `req_*` to `mem*`.

## Test plan
- **Word store then load:** store word 24 at byte address 36, then load word at byte address 36.
  - Store: `memWrite`=1 with `data_addr`=9 and `writeData`=24 in cycle 1; `resp_valid` in cycle 2.
  - Load: `memRead` in cycle 1; `resp_rdata`=24 in cycle 4 (L=2).
- **Sub-word store and sign/zero extension:** preload word 0x11223344 at address 12. Store byte 0xAB at address 13.
  - Required memory write: 0x1122AB44.
  - Signed byte load at 13 returns 0xFFFFFFAB.
  - Unsigned halfword load at 14 returns 0x00001122.
- **Misalignment:** word load at address 38 and halfword store at address 5.
  - Each gives `resp_err`=1 in cycle 1.
  - Zero `memRead`/`memWrite` assertions across the whole window.
- **Latency sweep:** repeat the word load at L=1 and at L=4.
  - `resp_valid` appears in cycle 3 and cycle 6 respectively.
  - The captured data matches the memory model in both cases.
- **Reset mid-operation:** raise `rst` in cycle 2 of a byte store.
  - No `memWrite` occurs afterwards and no `resp_valid` is issued.
  - All outputs read 0 during reset; `req_ready`=1 in the first cycle after release.
  - A following word load at address 36 returns the pre-reset memory contents.
